// File: rtl/result_display_pkg.sv
// Shared types and constants for the result display block: conversion FSM
// states, datapath widths, special segment patterns and the double-dabble
// nibble-adjust helper.
package result_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BIN_W       = 16;
    localparam int BCD_DIGITS  = 5;
    localparam int DISP_DIGITS = 4;
    localparam int BCD_W       = BCD_DIGITS * 4;

    // Active-low, bit order g f e d c b a
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Double-dabble correction: every nibble >= 5 gets +3 so the following
    // left shift carries correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        r = s;
        for (int k = 0; k < BCD_DIGITS; k++) begin
            if (s[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = s[4*k +: 4] + 4'd3;
            end else begin
                r[4*k +: 4] = s[4*k +: 4];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/result_display_seg7_decode.sv
// BCD digit to active-low seven-segment pattern (g f e d c b a).
// Non-decimal codes render as a blank digit.
module seg7_decode
    import result_display_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Pure lookup from digit value to segment pattern
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = 7'b1000000;
            4'd1:    o_seg = 7'b1111001;
            4'd2:    o_seg = 7'b0100100;
            4'd3:    o_seg = 7'b0110000;
            4'd4:    o_seg = 7'b0011001;
            4'd5:    o_seg = 7'b0010010;
            4'd6:    o_seg = 7'b0000010;
            4'd7:    o_seg = 7'b1111000;
            4'd8:    o_seg = 7'b0000000;
            4'd9:    o_seg = 7'b0010000;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/result_display.sv
// Converts a 16-bit unsigned result to five BCD digits with a sequential
// double-dabble engine, and multiplexes the low four digits onto a
// four-digit common-anode seven-segment display with leading-zero blanking
// and a dash pattern for values that do not fit in four digits.
module result_display
    import result_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic [BIN_W-1:0]  ans,
    input  logic              ans_valid,
    output logic              busy,
    output logic [BCD_W-1:0]  bcd,
    output logic              bcd_valid,
    output logic              ovf,
    output logic [6:0]        seg,
    output logic [3:0]        an
);

    localparam int              CNT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    // Conversion state
    state_t             r_state;
    logic               r_busy;
    logic [BCD_W-1:0]   r_scratch;
    logic [BIN_W-1:0]   r_bin;
    logic [3:0]         r_shift_cnt;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_bcd_valid;
    logic               r_ovf;
    logic [BCD_W-1:0]   w_adj;

    // Display state
    logic [CNT_W-1:0]   r_refresh_cnt;
    logic [1:0]         r_index;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;
    logic               w_wrap;
    logic [1:0]         w_index_next;
    logic [3:0]         w_digit;
    logic               w_blank;
    logic [6:0]         w_dec_seg;
    logic [6:0]         w_seg_next;
    logic [3:0]         w_an_next;

    assign w_adj = bcd_adjust(r_scratch);

    // Conversion FSM: capture, 16 adjust-and-shift steps, then publish
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_scratch   <= '0;
            r_bin       <= '0;
            r_shift_cnt <= 4'd0;
            r_bcd       <= '0;
            r_bcd_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_bcd_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (ans_valid) begin
                        r_bin       <= ans;
                        r_scratch   <= '0;
                        r_shift_cnt <= 4'd0;
                        r_busy      <= 1'b1;
                        r_state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_scratch   <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
                    r_bin       <= {r_bin[BIN_W-2:0], 1'b0};
                    r_shift_cnt <= r_shift_cnt + 4'd1;
                    if (r_shift_cnt == 4'd15) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_bcd       <= r_scratch;
                    r_ovf       <= (r_scratch[BCD_W-1 -: 4] != 4'd0);
                    r_bcd_valid <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Next digit slot and the segment pattern to show in it
    always_comb begin
        w_wrap       = (r_refresh_cnt == CNT_LAST);
        w_index_next = r_index;
        w_digit      = 4'd0;
        w_blank      = 1'b0;
        w_an_next    = 4'b1111;
        w_seg_next   = SEG_BLANK;

        if (w_wrap) begin
            w_index_next = r_index + 2'd1;
        end else begin
            w_index_next = r_index;
        end

        // A higher digit is blanked only when it and everything above it is zero
        case (w_index_next)
            2'd0: begin
                w_digit = r_bcd[3:0];
                w_blank = 1'b0;
            end
            2'd1: begin
                w_digit = r_bcd[7:4];
                w_blank = (r_bcd[15:4] == 12'd0);
            end
            2'd2: begin
                w_digit = r_bcd[11:8];
                w_blank = (r_bcd[15:8] == 8'd0);
            end
            2'd3: begin
                w_digit = r_bcd[15:12];
                w_blank = (r_bcd[15:12] == 4'd0);
            end
            default: begin
                w_digit = 4'd0;
                w_blank = 1'b0;
            end
        endcase

        w_an_next = ~(4'b0001 << w_index_next);

        if (r_ovf) begin
            w_seg_next = SEG_DASH;
        end else if (w_blank) begin
            w_seg_next = SEG_BLANK;
        end else begin
            w_seg_next = w_dec_seg;
        end
    end

    seg7_decode u_seg7_decode (
        .i_bcd (w_digit),
        .o_seg (w_dec_seg)
    );

    // Refresh timebase and registered digit drive; runs regardless of FSM
    always_ff @(posedge clock) begin
        if (reset) begin
            r_refresh_cnt <= '0;
            r_index       <= 2'd0;
            r_an          <= 4'b1110;
            r_seg         <= 7'b1000000;
        end else begin
            r_refresh_cnt <= w_wrap ? '0 : (r_refresh_cnt + 1'b1);
            r_index       <= w_index_next;
            r_an          <= w_an_next;
            r_seg         <= w_seg_next;
        end
    end

    assign busy      = r_busy;
    assign bcd       = r_bcd;
    assign bcd_valid = r_bcd_valid;
    assign ovf       = r_ovf;
    assign seg       = r_seg;
    assign an        = r_an;

endmodule

// File: doc/result_display.md
RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, meaning clock cycles per display digit slot (minimum 2).
REQ-002 SHALL have port clock  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port ans  input  16  unsigned arithmetic result to display.
REQ-005 SHALL have port ans_valid  input  1  one-cycle strobe; ans is sampled when this is high.
REQ-006 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-007 SHALL have port bcd  output  20  five BCD digits of the last completed conversion; bcd[3:0] is the units digit.
REQ-008 SHALL have port bcd_valid  output  1  one-cycle pulse when bcd updates.
REQ-009 SHALL have port ovf  output  1  high when the displayed value exceeds 9999.
REQ-010 SHALL have port seg  output  7  active-low segments, bit order g f e d c b a (seg[6] = g).
REQ-011 SHALL have port an  output  4  active-low one-hot digit enables; an[0] is the units digit.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 IDLE: when ans_valid=1, capture ans, clear the BCD scratch register and shift counter, and go to SHIFT.
REQ-014 SHIFT: each cycle, add 3 to every scratch nibble >= 5, then shift {scratch, binary} left by 1; after the 16th shift go to DONE.
REQ-015 DONE: copy scratch to bcd, pulse bcd_valid for exactly this cycle, and go to IDLE.
REQ-016 Latency: ans_valid sampled at edge N gives bcd_valid high in the cycle after edge N+17; total 18 cycles from strobe to next accepted strobe.
REQ-017 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-018 ans_valid while busy=1 SHALL be ignored, with no queuing and no effect on the conversion in progress.
REQ-019 bcd and ovf SHALL change only in DONE; ovf = (bcd[19:16] != 0).
REQ-020 Refresh counter counts 0..REFRESH_DIV-1 and wraps; on wrap, the digit index advances 0->1->2->3->0.
REQ-021 an = ~(1 << index).
REQ-022 seg SHALL show the BCD digit at position index, decoded as follows:
- 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
- 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
REQ-023 Leading-zero blanking: digit k (k>0) SHALL be blank (1111111) when it and all higher digits are 0; digit 0 is always shown.
REQ-024 When ovf=1, every slot SHALL show dash (0111111).
REQ-025 Display SHALL continue refreshing during conversion, showing the previous bcd.

Reset
REQ-026 On reset: FSM to IDLE, busy=0, bcd=0, bcd_valid=0, ovf=0, refresh counter=0, index=0; outputs are therefore an=1110 and seg=1000000.
REQ-027 Reset during SHIFT or DONE SHALL abort the conversion, with no bcd_valid pulse and bcd cleared.
REQ-028 reset has priority over a simultaneous ans_valid; that strobe is dropped.

Structure
REQ-029 Package result_display_pkg SHALL hold:
- FSM state enum
- constants BIN_W=16, BCD_DIGITS=5, DISP_DIGITS=4
- segment constants SEG_BLANK, SEG_DASH
REQ-030 Combinational sub-module seg7_decode (4-bit BCD in, 7-bit active-low seg out) SHALL be instantiated once; codes 10-15 decode to SEG_BLANK.

Verification
REQ-031 ans=225, strobe -> after 17 cycles: bcd=20'h00225, bcd_valid high 1 cycle, ovf=0; display reads blank,2,2,5.
REQ-032 ans=0 -> bcd=0; an=1110 slot shows 1000000; other slots show 1111111.
REQ-033 ans=65535 -> bcd=20'h65535, ovf=1; all four slots show 0111111.
REQ-034 ans=225 strobe, then ans=15 strobe 5 cycles later -> only one bcd_valid; bcd=20'h00225; busy low 18 cycles after first strobe.
REQ-035 Reset asserted on the 8th SHIFT cycle -> next cycle busy=0 and bcd=0; no bcd_valid ever pulses.
REQ-036 REFRESH_DIV=4 -> an cycles 1110, 1101, 1011, 0111, each held 4 cycles, then wraps to 1110.
